// File: rtl/zeroriscy_host_if.sv
// Host-interface responder on the zero-riscy data port: console stores feed a byte
// FIFO drained by an 8N1 UART; tohost stores are latched and decoded to pass/fail.
`timescale 1ns/1ps
module zeroriscy_host_if #(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        uart_tx_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        pass_o,
  output logic        fail_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0] CONSOLE_ADDR = 32'h9a10_0000;
  localparam logic [31:0] TOHOST_ADDR0 = 32'h8000_1000;
  localparam logic [31:0] TOHOST_ADDR1 = 32'h8000_3000;
  localparam logic [31:0] TOHOST_ADDR2 = 32'h8017_fffc;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  logic          is_console, is_tohost, mapped;
  logic          console_store, tohost_store, tohost_write;
  logic          fifo_full, fifo_empty, push, pop, bit_end;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, level;
  logic [7:0]    level8;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [31:0]   rdata_d;
  logic          unused_be;

  uart_state_e   state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic          rvalid_q, err_q, tohost_valid_q, pass_q, fail_q;
  logic [31:0]   rdata_q, tohost_data_q;

  assign is_console = (data_addr_i == CONSOLE_ADDR);
  assign is_tohost  = (data_addr_i == TOHOST_ADDR0) || (data_addr_i == TOHOST_ADDR1) ||
                      (data_addr_i == TOHOST_ADDR2);
  assign mapped     = is_console | is_tohost;

  assign console_store = data_req_i & data_we_i & is_console;
  assign tohost_store  = data_req_i & data_we_i & is_tohost;
  assign unused_be     = ^data_be_i[3:1];

  assign level      = wr_ptr_q - rd_ptr_q;
  assign level8     = 8'(level);
  assign fifo_full  = (level == PW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign bit_end    = (bit_cnt_q == CW'(CLKS_PER_BIT - 1));

  // The UART pops at the end of IDLE or STOP; that pop frees a slot for a waiting store.
  assign pop          = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end));
  assign data_gnt_o   = data_req_i & ~(console_store & fifo_full & ~pop);
  assign push         = data_gnt_o & console_store & data_be_i[0];
  assign tohost_write = data_gnt_o & tohost_store & (data_wdata_i != '0);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rdata_d = '0;
    if (!data_we_i) begin
      if (is_console)     rdata_d = {23'b0, fifo_full, level8};
      else if (is_tohost) rdata_d = tohost_data_q;
    end
  end

  // NOTE: storage array carries no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= data_wdata_i[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      rvalid_q       <= data_gnt_o;
      rdata_q        <= (data_gnt_o && mapped) ? rdata_d : '0;
      err_q          <= data_gnt_o & ~mapped;
      tohost_valid_q <= tohost_write;
      if (tohost_write) begin
        tohost_data_q <= data_wdata_i;
        // Status is decided by the first non-zero store only.
        if (!pass_q && !fail_q) begin
          pass_q <= (data_wdata_i == 32'd1);
          fail_q <= (data_wdata_i != 32'd1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q   <= ST_START;
            bit_cnt_q <= '0;
            shift_q   <= fifo_mem[rd_ptr_q[AW-1:0]];
            tx_q      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (pop) begin
              state_q <= ST_START;
              shift_q <= fifo_mem[rd_ptr_q[AW-1:0]];
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign data_err_o     = err_q;
  assign uart_tx_o      = tx_q;
  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;

endmodule

// File: tb/tb_zeroriscy_host_if.sv
// Directed bench for zeroriscy_host_if with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_zeroriscy_host_if;

  localparam logic [31:0] CONSOLE = 32'h9a10_0000;
  localparam logic [31:0] TH0     = 32'h8000_1000;
  localparam logic [31:0] TH1     = 32'h8000_3000;
  localparam logic [31:0] TH2     = 32'h8017_fffc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o, uart_tx_o;
  logic [31:0] data_rdata_o, tohost_data_o;
  logic        tohost_valid_o, pass_o, fail_o;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;
  logic [7:0] rx_q [$];
  longint     rx_t [$];

  zeroriscy_host_if #(.FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o), .uart_tx_o(uart_tx_o),
    .tohost_valid_o(tohost_valid_o), .tohost_data_o(tohost_data_o),
    .pass_o(pass_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the response cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int waited);
    waited = 0;
    rd = '0;
    er = 1'b0;
    data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
    #1;
    while (!data_gnt_o && waited < 200) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!data_gnt_o) begin
      check("gnt_timeout", 32'(data_gnt_o), 32'd1);
      data_req_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    data_req_i = 1'b0;
    check("rvalid", 32'(data_rvalid_o), 32'd1);
    rd = data_rdata_o;
    er = data_err_o;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // UART monitor: samples the second cycle of each bit cell.
  initial begin
    logic [9:0] f;
    longint t0;
    forever begin
      @(negedge uart_tx_o);
      t0 = $time;
      @(negedge clk); @(negedge clk);
      f[0] = uart_tx_o;
      for (int k = 1; k < 10; k++) begin
        repeat (4) @(negedge clk);
        f[k] = uart_tx_o;
      end
      if (mon_en) begin
        check("uart_start", 32'(f[0]), 32'd0);
        check("uart_stop", 32'(f[9]), 32'd1);
        rx_q.push_back(f[8:1]);
        rx_t.push_back(t0);
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    logic [9:0]  frame;
    logic [7:0]  burst [6];
    int          stall [6];

    burst = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    rst_n = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = CONSOLE; data_be_i = 4'h0;
    data_wdata_i = '0;

    // Reset held with a pending request.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_rvalid", 32'(data_rvalid_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_fail", 32'(fail_o), 32'd0);
    check("rst_gnt", 32'(data_gnt_o), 32'd1);
    check("rst_thdata", tohost_data_o, 32'd0);
    data_req_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rvalid", 32'(data_rvalid_o), 32'd0);

    // Single console character, exact per-cycle line waveform.
    access(1'b1, CONSOLE, 4'hf, 32'h0000_0041, rd, er, w);
    check("char_err", 32'(er), 32'd0);
    check("char_latency_tx", 32'(uart_tx_o), 32'd1);
    frame = {1'b1, 8'h41, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("char_tx%0d", i), 32'(uart_tx_o), 32'(frame[i/4]));
    end
    check("char_rx_count", 32'(rx_q.size()), 32'd1);
    rx_q.delete();
    rx_t.delete();

    // Console store with byte 0 disabled pushes nothing.
    access(1'b1, CONSOLE, 4'b1110, 32'h0000_0055, rd, er, w);
    access(1'b0, CONSOLE, 4'hf, 32'h0, rd, er, w);
    check("be0_level", rd, 32'h0000_0000);

    // Back-to-back burst into a 4-deep FIFO; only the sixth store stalls.
    for (int i = 0; i < 6; i++) begin
      access(1'b1, CONSOLE, 4'h1, {24'h0, burst[i]}, rd, er, w);
      stall[i] = w;
      check($sformatf("burst_stall%0d", i), 32'(stall[i] > 0), 32'(i == 5));
    end
    access(1'b0, CONSOLE, 4'hf, 32'h0, rd, er, w);
    check("burst_level", rd, 32'h0000_0104);
    w = 0;
    while (rx_q.size() < 6 && w < 600) begin
      @(posedge clk);
      w++;
    end
    check("burst_rx_count", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check($sformatf("burst_byte%0d", i), 32'(rx_q[i]), 32'(burst[i]));
    for (int i = 1; i < 6 && i < rx_t.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'd400);
    @(posedge clk); #1;

    // Tohost pass path.
    access(1'b1, TH0, 4'hf, 32'd0, rd, er, w);
    check("th0_valid", 32'(tohost_valid_o), 32'd0);
    check("th0_pass", 32'(pass_o), 32'd0);
    access(1'b1, TH0, 4'hf, 32'd1, rd, er, w);
    check("th1_valid", 32'(tohost_valid_o), 32'd1);
    check("th1_data", tohost_data_o, 32'd1);
    check("th1_pass", 32'(pass_o), 32'd1);
    check("th1_fail", 32'(fail_o), 32'd0);
    @(posedge clk); #1;
    check("th1_valid_drop", 32'(tohost_valid_o), 32'd0);
    access(1'b1, TH1, 4'hf, 32'd5, rd, er, w);
    check("th5_data", tohost_data_o, 32'd5);
    check("th5_fail", 32'(fail_o), 32'd0);
    check("th5_pass", 32'(pass_o), 32'd1);

    // Tohost fail path after reset.
    pulse_reset();
    check("rst2_pass", 32'(pass_o), 32'd0);
    access(1'b1, TH2, 4'hf, 32'h0000_000b, rd, er, w);
    check("thb_fail", 32'(fail_o), 32'd1);
    check("thb_pass", 32'(pass_o), 32'd0);
    access(1'b0, TH2, 4'hf, 32'h0, rd, er, w);
    check("thb_load", rd, 32'h0000_000b);
    check("thb_load_err", 32'(er), 32'd0);

    // Unmapped accesses.
    access(1'b0, 32'h9000_0000, 4'hf, 32'h0, rd, er, w);
    check("unmap_err", 32'(er), 32'd1);
    check("unmap_rdata", rd, 32'd0);
    access(1'b1, 32'h9a10_0004, 4'hf, 32'h0000_0077, rd, er, w);
    check("unmap_st_err", 32'(er), 32'd1);
    access(1'b0, CONSOLE, 4'hf, 32'h0, rd, er, w);
    check("unmap_st_level", rd, 32'd0);
    check("unmap_st_data", tohost_data_o, 32'h0000_000b);

    // Reset during DATA bit 3 of 0xA5 with a second byte queued.
    mon_en = 1'b0;
    access(1'b1, CONSOLE, 4'h1, 32'h0000_00a5, rd, er, w);
    access(1'b1, CONSOLE, 4'h1, 32'h0000_003c, rd, er, w);
    repeat (17) @(posedge clk);
    #1;
    check("mid_bit3", 32'(uart_tx_o), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_tx", 32'(uart_tx_o), 32'd1);
    rst_n = 1'b1;
    access(1'b0, CONSOLE, 4'hf, 32'h0, rd, er, w);
    check("mid_rst_level", rd, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_idle", 32'(uart_tx_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zeroriscy_host_if.md
# zeroriscy_host_if

Synthesizable host-interface responder on the zero-riscy data port. It is the target-side end of the console and tohost protocol that the simulation benches only snoop. The core's stores to the console address are queued in a byte FIFO and shifted out as 8N1 UART frames. Stores to the tohost addresses are latched and decoded into pass/fail status for FPGA builds, where no testbench is present.

## Interface
- `FIFO_DEPTH`, 16: console FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 868: clocks per UART bit; ≥4.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on `clk`.
- `data_req_i` input 1: request from core; already decoded to this block by top-level interconnect.
- `data_addr_i` input 32: byte address.
- `data_we_i` input 1: 1 = store.
- `data_be_i` input 4: byte enables.
- `data_wdata_i` input 32: store data.
- `data_gnt_o` output 1: request accepted this cycle.
- `data_rvalid_o` output 1: response valid; exactly one per grant.
- `data_rdata_o` output 32: load data, valid with `data_rvalid_o`.
- `data_err_o` output 1: unmapped address, valid with `data_rvalid_o`.
- `uart_tx_o` output 1: serial console output, idle high.
- `tohost_valid_o` output 1: one-cycle pulse on a non-zero tohost store.
- `tohost_data_o` output 32: last non-zero tohost value.
- `pass_o` output 1: sticky; set when tohost == 1.
- `fail_o` output 1: sticky; set when tohost is non-zero and ≠ 1.

## Operation
- Address map, full 32-bit compare:
  - CONSOLE = 0x9a100000.
  - TOHOST = 0x80001000, 0x80003000, 0x8017fffc.
  - Any other address is unmapped.
- Console store: push `data_wdata_i[7:0]` into the FIFO when `data_be_i[0]`=1. If `data_be_i[0]`=0, grant and respond, but push nothing.
- Console load: `data_rdata_o` = {23'b0, full, level[7:0]}. `level` is the current FIFO occupancy, zero-extended.
- Tohost store with `data_wdata_i`≠0:
  - latch `tohost_data_o`;
  - pulse `tohost_valid_o`;
  - set `pass_o` if the value is 1, otherwise set `fail_o`.
  - Only the first non-zero store sets a status bit; afterwards `pass_o`/`fail_o` are frozen until reset. `tohost_data_o` still updates on each non-zero store.
- Tohost store of 0: granted, but no state change.
- Tohost load: returns `tohost_data_o`.
- Unmapped access:
  - granted;
  - `data_err_o`=1, `data_rdata_o`=0;
  - a store has no effect.
- Byte enables other than bit 0 are ignored for console. Tohost treats stores as full-word writes.
- UART transmitter states: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, pop one byte and enter START in the same cycle.
  - Each state holds for exactly `CLKS_PER_BIT` cycles, counted by a bit-timer.
  - Line levels: START = 0, DATA = data bits, STOP = 1.
  - At the end of STOP with the FIFO non-empty, go directly to START with no idle gap.
- FIFO: circular, read/write pointers of log2(`FIFO_DEPTH`)+1 bits. A simultaneous push and pop while full or empty is legal; level stays consistent.

## Timing
- Reset values (`rst_n`=0 at a rising edge): FIFO empty, UART in IDLE, `uart_tx_o`=1, `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, `tohost_valid_o`=0, `tohost_data_o`=0, `pass_o`=0, `fail_o`=0.
- Reset mid-frame aborts the frame: the line returns to 1 on the next cycle and queued bytes are discarded.
- `data_gnt_o` is combinational: `data_req_i` AND NOT(console store AND FIFO full). A full FIFO stalls the core with no loss; the grant arrives in the first cycle a slot is free.
- A pop in the same cycle frees a slot: full-FIFO grant is allowed when the UART pops that cycle.
- Response: `data_rvalid_o`, `data_rdata_o` and `data_err_o` are registered and asserted the cycle after `data_gnt_o`. Back-to-back grants produce back-to-back rvalids.
- Store side effects (FIFO push, tohost latch) take effect at the granting edge:
  - FIFO level is visible to a load issued on the next cycle;
  - `tohost_valid_o` goes high in the cycle after the grant, for exactly one cycle;
  - `pass_o`/`fail_o` assert in that same cycle.
- Latency from a console store grant into an empty, idle block to the start-bit falling edge: 2 cycles (push, then pop).
- Frame length: 10 × `CLKS_PER_BIT` cycles.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `data_req_i`=1 → `uart_tx_o`=1, `data_rvalid_o`=0, pass/fail=0. Grant is allowed, but no rvalid appears until rst_n=1.
- Console char, `CLKS_PER_BIT`=4: store 0x00000041 to 0x9a100000 → rvalid 1 cycle later. Line: start 0; bits 1,0,0,0,0,0,1,0; stop 1; each level held 4 cycles, 40 cycles total.
- Backpressure, `FIFO_DEPTH`=4: issue 6 back-to-back console stores "ABCDEF" → gnt low once full and asserted again as each pop occurs. UART emits A–F in order with no inter-frame gap; a console load mid-burst returns the correct level.
- Tohost pass: store 0 then 1 to 0x80001000 → store 0 causes no pulse. Store 1 gives a `tohost_valid_o` pulse, `tohost_data_o`=1 and `pass_o`=1. A subsequent store of 5 leaves `fail_o`=0 and sets `tohost_data_o`=5.
- Tohost fail: store 0x0000000B to 0x8017fffc → `fail_o`=1, `pass_o`=0. A tohost load returns 0x0000000B.
- Unmapped plus reset mid-frame:
  - Load from 0x90000000 → rvalid with `data_err_o`=1 and rdata=0.
  - Assert `rst_n`=0 during DATA bit 3 → `uart_tx_o`=1 next cycle, FIFO level reads 0 after reset.
